// File: rtl/data_mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl_if
//   Request/response bus between a core MEM stage (master) and the data memory
//   controller (slave). Also carries the init_busy status flag.
//   Signals:
//     req_valid/req_ready  request handshake (master -> slave)
//     req_wr, req_op       1 = store / 0 = load, memory op code (MEM_* codes)
//     req_addr, req_wdata  byte address, right-aligned store data
//     resp_valid/ready     response handshake (slave -> master)
//     resp_rdata, resp_err load result, access-rejected flag
//     init_busy            hardware clear after reset in progress
// -----------------------------------------------------------------------------
`ifndef MEM_OP_CODES_DEFINED
`define MEM_OP_CODES_DEFINED
`define MEM_LB  4'd0
`define MEM_LH  4'd1
`define MEM_LW  4'd2
`define MEM_LBU 4'd3
`define MEM_LHU 4'd4
`define MEM_SB  4'd5
`define MEM_SH  4'd6
`define MEM_SW  4'd7
`endif

interface data_mem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [3:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        init_busy;

    modport slave (
        input  req_valid, req_wr, req_op, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err, init_busy
    );

    modport master (
        output req_valid, req_wr, req_op, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err, init_busy
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
//   Word-organised data memory (2**ADDR_WIDTH x 32 bit) behind a valid/ready
//   request/response handshake. After reset the whole array is cleared, one
//   word per cycle, while init_busy is high. One request is outstanding at a
//   time; its response appears LATENCY cycles after the accept edge and is
//   held until the consumer takes it. Misaligned, out-of-range and illegal
//   accesses are answered with resp_err=1, rdata=0 and leave memory untouched.
//   Byte lanes are little-endian (byte 0 = bits [7:0]).
//   Ports:
//     clk  clock, all state on rising edge
//     rst  asynchronous active-high reset
//     bus  data_mem_ctrl_if.slave (request, response, init_busy)
// -----------------------------------------------------------------------------
module data_mem_ctrl #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 1
) (
    input  logic            clk,
    input  logic            rst,
    data_mem_ctrl_if.slave  bus
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic [ADDR_WIDTH-1:0]   clr_cnt_r;
    logic [3:0]              wait_cnt_r;

    logic                    lat_wr_r;
    logic [3:0]              lat_op_r;
    logic [31:0]             lat_addr_r;
    logic [31:0]             lat_wdata_r;

    logic                    req_ready_r;
    logic                    resp_valid_r;
    logic [31:0]             resp_rdata_r;
    logic                    resp_err_r;
    logic                    init_busy_r;

    logic [31:0]             mem_r [DEPTH];

    logic                    accept_s;
    logic                    access_s;
    logic                    done_s;
    logic [ADDR_WIDTH-1:0]   word_idx_s;
    logic                    align_err_s;
    logic                    range_err_s;
    logic                    op_err_s;
    logic                    err_s;
    logic [31:0]             rd_word_s;
    logic [7:0]              rd_byte_s;
    logic [15:0]             rd_half_s;
    logic [31:0]             load_data_s;
    logic [3:0]              be_s;
    logic [31:0]             wlane_s;
    logic                    write_s;

    function automatic logic op_is_load(input logic [3:0] op);
        return (op == `MEM_LB) || (op == `MEM_LH) || (op == `MEM_LW) ||
               (op == `MEM_LBU) || (op == `MEM_LHU);
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return (op == `MEM_SB) || (op == `MEM_SH) || (op == `MEM_SW);
    endfunction

    // Next-state decode and per-cycle handshake events.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        access_s = 1'b0;
        done_s   = 1'b0;
        case (state_r)
            ST_INIT: begin
                // The counter wraps to zero on the same edge that leaves INIT.
                if (&clr_cnt_r) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_INIT;
                end
            end
            ST_IDLE: begin
                if (bus.req_valid && req_ready_r) begin
                    accept_s = 1'b1;
                    state_s  = ST_WAIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (wait_cnt_r == 4'd0) begin
                    access_s = 1'b1;
                    state_s  = ST_RESP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (bus.resp_ready) begin
                    done_s  = 1'b1;
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: begin
                state_s = ST_INIT;
            end
        endcase
    end

    // Access checks on the latched request.
    always_comb begin
        word_idx_s  = lat_addr_r[ADDR_WIDTH+1:2];
        range_err_s = ((lat_addr_r >> (ADDR_WIDTH + 2)) != 32'd0);
        align_err_s = 1'b0;
        op_err_s    = 1'b0;
        case (lat_op_r)
            `MEM_LB, `MEM_LBU, `MEM_SB: align_err_s = 1'b0;
            `MEM_LH, `MEM_LHU, `MEM_SH: align_err_s = lat_addr_r[0];
            `MEM_LW, `MEM_SW:           align_err_s = (lat_addr_r[1:0] != 2'd0);
            default:                    align_err_s = 1'b0;
        endcase
        if (op_is_load(lat_op_r)) begin
            op_err_s = lat_wr_r;
        end else if (op_is_store(lat_op_r)) begin
            op_err_s = !lat_wr_r;
        end else begin
            op_err_s = 1'b1;
        end
        err_s = align_err_s || range_err_s || op_err_s;
    end

    // Load lane selection and sign/zero extension.
    always_comb begin
        rd_word_s   = mem_r[word_idx_s];
        rd_byte_s   = rd_word_s[{lat_addr_r[1:0], 3'b000} +: 8];
        rd_half_s   = lat_addr_r[1] ? rd_word_s[31:16] : rd_word_s[15:0];
        load_data_s = 32'd0;
        case (lat_op_r)
            `MEM_LB:  load_data_s = {{24{rd_byte_s[7]}}, rd_byte_s};
            `MEM_LBU: load_data_s = {24'd0, rd_byte_s};
            `MEM_LH:  load_data_s = {{16{rd_half_s[15]}}, rd_half_s};
            `MEM_LHU: load_data_s = {16'd0, rd_half_s};
            `MEM_LW:  load_data_s = rd_word_s;
            default:  load_data_s = 32'd0;
        endcase
    end

    // Store byte enables; data is replicated so every enabled lane sees it.
    always_comb begin
        be_s    = 4'b0000;
        wlane_s = lat_wdata_r;
        case (lat_op_r)
            `MEM_SB: begin
                be_s    = 4'b0001 << lat_addr_r[1:0];
                wlane_s = {4{lat_wdata_r[7:0]}};
            end
            `MEM_SH: begin
                be_s    = lat_addr_r[1] ? 4'b1100 : 4'b0011;
                wlane_s = {2{lat_wdata_r[15:0]}};
            end
            `MEM_SW: begin
                be_s    = 4'b1111;
                wlane_s = lat_wdata_r;
            end
            default: begin
                be_s    = 4'b0000;
                wlane_s = lat_wdata_r;
            end
        endcase
        write_s = access_s && lat_wr_r && !err_s;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= state_s;
        end
    end

    // Clear counter and latency counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_cnt_r  <= '0;
            wait_cnt_r <= 4'd0;
        end else begin
            if (state_r == ST_INIT) begin
                clr_cnt_r <= clr_cnt_r + ADDR_WIDTH'(1);
            end else begin
                clr_cnt_r <= '0;
            end
            if (accept_s) begin
                wait_cnt_r <= 4'(LATENCY - 1);
            end else if ((state_r == ST_WAIT) && (wait_cnt_r != 4'd0)) begin
                wait_cnt_r <= wait_cnt_r - 4'd1;
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
        end
    end

    // Request capture on accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_wr_r    <= 1'b0;
            lat_op_r    <= 4'd0;
            lat_addr_r  <= 32'd0;
            lat_wdata_r <= 32'd0;
        end else if (accept_s) begin
            lat_wr_r    <= bus.req_wr;
            lat_op_r    <= bus.req_op;
            lat_addr_r  <= bus.req_addr;
            lat_wdata_r <= bus.req_wdata;
        end else begin
            lat_wr_r    <= lat_wr_r;
            lat_op_r    <= lat_op_r;
            lat_addr_r  <= lat_addr_r;
            lat_wdata_r <= lat_wdata_r;
        end
    end

    // Registered bus outputs; ready/busy follow the state being entered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_ready_r  <= 1'b0;
            init_busy_r  <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'd0;
            resp_err_r   <= 1'b0;
        end else begin
            req_ready_r <= (state_s == ST_IDLE);
            init_busy_r <= (state_s == ST_INIT);
            if (access_s) begin
                resp_valid_r <= 1'b1;
                resp_err_r   <= err_s;
                resp_rdata_r <= (err_s || lat_wr_r) ? 32'd0 : load_data_s;
            end else if (done_s) begin
                resp_valid_r <= 1'b0;
                resp_err_r   <= 1'b0;
                resp_rdata_r <= 32'd0;
            end else begin
                resp_valid_r <= resp_valid_r;
                resp_err_r   <= resp_err_r;
                resp_rdata_r <= resp_rdata_r;
            end
        end
    end

    // Memory array: hardware clear during INIT, byte-enable merge on store.
    always_ff @(posedge clk) begin
        if (state_r == ST_INIT) begin
            mem_r[clr_cnt_r] <= 32'd0;
        end else if (write_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_r[word_idx_s][8*i +: 8] <= wlane_s[8*i +: 8];
                end
            end
        end
    end

    assign bus.req_ready  = req_ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign bus.resp_err   = resp_err_r;
    assign bus.init_busy  = init_busy_r;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_data_mem_ctrl
//   Two instances: dut0 (ADDR_WIDTH=10, LATENCY=1) and dut1 (ADDR_WIDTH=10,
//   LATENCY=4). Shared stimulus registers are steered to one of them by sel.
//   A byte-level reference model of dut0's memory predicts every load.
// -----------------------------------------------------------------------------
`ifndef MEM_OP_CODES_DEFINED
`define MEM_OP_CODES_DEFINED
`define MEM_LB  4'd0
`define MEM_LH  4'd1
`define MEM_LW  4'd2
`define MEM_LBU 4'd3
`define MEM_LHU 4'd4
`define MEM_SB  4'd5
`define MEM_SH  4'd6
`define MEM_SW  4'd7
`endif

module tb_data_mem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0, rst1;
    int          sel;
    logic        r_valid, r_wr, r_rready;
    logic [3:0]  r_op;
    logic [31:0] r_addr, r_wdata;
    logic        o_ready, o_valid, o_err, o_busy;
    logic [31:0] o_rdata;

    int errors = 0;
    int checks = 0;
    logic [31:0] model_mem [1024];

    data_mem_ctrl_if bus0 ();
    data_mem_ctrl_if bus1 ();

    data_mem_ctrl #(.ADDR_WIDTH(10), .LATENCY(1)) dut0 (.clk(clk), .rst(rst0), .bus(bus0.slave));
    data_mem_ctrl #(.ADDR_WIDTH(10), .LATENCY(4)) dut1 (.clk(clk), .rst(rst1), .bus(bus1.slave));

    assign bus0.req_valid  = r_valid && (sel == 0);
    assign bus1.req_valid  = r_valid && (sel == 1);
    assign bus0.resp_ready = r_rready && (sel == 0);
    assign bus1.resp_ready = r_rready && (sel == 1);
    assign bus0.req_wr = r_wr;     assign bus1.req_wr = r_wr;
    assign bus0.req_op = r_op;     assign bus1.req_op = r_op;
    assign bus0.req_addr = r_addr; assign bus1.req_addr = r_addr;
    assign bus0.req_wdata = r_wdata; assign bus1.req_wdata = r_wdata;

    assign o_ready = (sel == 0) ? bus0.req_ready  : bus1.req_ready;
    assign o_valid = (sel == 0) ? bus0.resp_valid : bus1.resp_valid;
    assign o_rdata = (sel == 0) ? bus0.resp_rdata : bus1.resp_rdata;
    assign o_err   = (sel == 0) ? bus0.resp_err   : bus1.resp_err;
    assign o_busy  = (sel == 0) ? bus0.init_busy  : bus1.init_busy;

    // Reference model: byte-addressed view of a 4 KiB memory.
    function automatic void model_step(input logic wr, input logic [3:0] op,
                                       input logic [31:0] addr, input logic [31:0] wdata,
                                       output logic [31:0] rd, output logic er);
        int size = 1;
        bit sgn = 0, is_st = 0, known = 1;
        int unsigned w, off;
        logic [31:0] val;
        case (op)
            `MEM_LB:  begin size = 1; sgn = 1; end
            `MEM_LBU: begin size = 1; end
            `MEM_LH:  begin size = 2; sgn = 1; end
            `MEM_LHU: begin size = 2; end
            `MEM_LW:  begin size = 4; end
            `MEM_SB:  begin size = 1; is_st = 1; end
            `MEM_SH:  begin size = 2; is_st = 1; end
            `MEM_SW:  begin size = 4; is_st = 1; end
            default:  known = 0;
        endcase
        er = !known || (is_st != bit'(wr)) || ((addr % size) != 0) || ({32'd0, addr} >= 64'd4096);
        rd = 32'd0;
        if (!er) begin
            w = addr / 4;
            off = addr % 4;
            if (is_st) begin
                for (int b = 0; b < size; b++)
                    model_mem[w][(off + b) * 8 +: 8] = wdata[b * 8 +: 8];
            end else begin
                val = 32'd0;
                for (int b = 0; b < size; b++)
                    val[b * 8 +: 8] = model_mem[w][(off + b) * 8 +: 8];
                if (sgn && val[size * 8 - 1])
                    for (int k = size * 8; k < 32; k++) val[k] = 1'b1;
                rd = val;
            end
        end
    endfunction

    // Bus driver for the selected DUT. On a timeout the outputs stay X so
    // the caller's comparisons fail.
    task automatic do_req(input logic wr, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] wdata, input int stall,
                          output logic [31:0] rd, output logic er, output int lat,
                          output bit held_ok, output bit ready_after);
        int n;
        rd = 32'hxxxxxxxx; er = 1'bx; lat = -1; held_ok = 0; ready_after = 0;
        n = 0;
        while (!o_ready && n < 3000) begin @(negedge clk); n++; end
        if (!o_ready) return;
        r_valid = 1'b1; r_wr = wr; r_op = op; r_addr = addr; r_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        r_valid = 1'b0;
        held_ok = 1;
        n = 0;
        while (!o_valid && n < 40) begin
            if (o_ready) held_ok = 0;
            @(negedge clk);
            n++;
        end
        if (!o_valid) return;
        lat = n;
        rd = o_rdata;
        er = o_err;
        if (o_ready) held_ok = 0;
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            if (!o_valid || o_rdata !== rd || o_err !== er || o_ready) held_ok = 0;
        end
        r_rready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        r_rready = 1'b0;
        ready_after = o_ready && !o_valid;
    endtask

    task automatic test_reset();
        int n;
        bit early;
        logic [31:0] rd; logic er; int lat; bit h, ra;
        sel = 0; r_valid = 0; r_wr = 0; r_rready = 0; r_op = 4'd0; r_addr = 32'd0; r_wdata = 32'd0;
        rst0 = 1'b1; rst1 = 1'b1;
        for (int i = 0; i < 1024; i++) model_mem[i] = 32'd0;
        @(negedge clk);
        checks++;
        if ({bus0.req_ready, bus0.resp_valid, bus0.resp_err, bus0.init_busy} !== 4'b0001) begin
            errors++; $display("FAIL reset_flags: got %b expected 0001", {bus0.req_ready, bus0.resp_valid, bus0.resp_err, bus0.init_busy});
        end
        checks++;
        if (bus0.resp_rdata !== 32'd0) begin
            errors++; $display("FAIL reset_rdata: got %h expected 00000000", bus0.resp_rdata);
        end
        @(negedge clk);
        rst0 = 1'b0; rst1 = 1'b0;
        n = 0; early = 0;
        while (bus0.init_busy && n < 3000) begin
            if (bus0.req_ready || bus0.resp_valid) early = 1;
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != 1024) begin errors++; $display("FAIL init_cycles: got %0d expected 1024", n); end
        checks++;
        if (early) begin errors++; $display("FAIL init_ready_low: got ready/valid high during clear expected low"); end
        checks++;
        if (bus0.req_ready !== 1'b1) begin errors++; $display("FAIL ready_after_init: got %b expected 1", bus0.req_ready); end
        checks++;
        if ({bus1.init_busy, bus1.req_ready} !== 2'b01) begin
            errors++; $display("FAIL dut1_init_done: got %b expected 01", {bus1.init_busy, bus1.req_ready});
        end
        do_req(1'b0, `MEM_LW, 32'h3FC, 32'd0, 0, rd, er, lat, h, ra);
        checks++;
        if (rd !== 32'd0 || er !== 1'b0) begin
            errors++; $display("FAIL lw_after_clear: got %h/%b expected 00000000/0", rd, er);
        end
    endtask

    task automatic test_byte_half();
        logic [31:0] rd, mrd; logic er, mer; int lat; bit h, ra;
        logic [3:0]  ops  [4] = '{`MEM_LB, `MEM_LBU, `MEM_LH, `MEM_LHU};
        logic [31:0] adrs [4] = '{32'h10, 32'h11, 32'h12, 32'h12};
        logic [31:0] exps [4] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF8001, 32'h00008001};
        sel = 0;
        model_step(1'b1, `MEM_SW, 32'h10, 32'h80017F80, mrd, mer);
        do_req(1'b1, `MEM_SW, 32'h10, 32'h80017F80, 0, rd, er, lat, h, ra);
        checks++;
        if (rd !== 32'd0 || er !== 1'b0 || lat != 1) begin
            errors++; $display("FAIL sw_resp: got %h/%b lat %0d expected 00000000/0 lat 1", rd, er, lat);
        end
        for (int i = 0; i < 4; i++) begin
            model_step(1'b0, ops[i], adrs[i], 32'd0, mrd, mer);
            do_req(1'b0, ops[i], adrs[i], 32'd0, 0, rd, er, lat, h, ra);
            checks++;
            if (rd !== exps[i] || er !== 1'b0) begin
                errors++; $display("FAIL subword_load%0d: got %h/%b expected %h/0", i, rd, er, exps[i]);
            end
        end
    endtask

    task automatic test_partial_store();
        logic [31:0] rd, mrd; logic er, mer; int lat; bit h, ra;
        sel = 0;
        model_step(1'b1, `MEM_SB, 32'h13, 32'h000000AB, mrd, mer);
        do_req(1'b1, `MEM_SB, 32'h13, 32'h000000AB, 0, rd, er, lat, h, ra);
        do_req(1'b0, `MEM_LW, 32'h10, 32'd0, 0, rd, er, lat, h, ra);
        checks++;
        if (rd !== 32'hAB017F80 || er !== 1'b0) begin
            errors++; $display("FAIL sb_merge: got %h/%b expected ab017f80/0", rd, er);
        end
        model_step(1'b1, `MEM_SH, 32'h10, 32'h00001234, mrd, mer);
        do_req(1'b1, `MEM_SH, 32'h10, 32'h00001234, 0, rd, er, lat, h, ra);
        do_req(1'b0, `MEM_LW, 32'h10, 32'd0, 0, rd, er, lat, h, ra);
        checks++;
        if (rd !== 32'hAB011234 || er !== 1'b0) begin
            errors++; $display("FAIL sh_merge: got %h/%b expected ab011234/0", rd, er);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd, mrd; logic er, mer; int lat; bit h, ra;
        logic        wrs  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [3:0]  ops  [6] = '{`MEM_LW, `MEM_SH, `MEM_SW, `MEM_SW, 4'hF, `MEM_LB};
        logic [31:0] adrs [6] = '{32'h2, 32'h5, 32'h1000, 32'h10, 32'h10, 32'h10};
        sel = 0;
        for (int i = 0; i < 6; i++) begin
            model_step(wrs[i], ops[i], adrs[i], 32'hFFFFFFFF, mrd, mer);
            do_req(wrs[i], ops[i], adrs[i], 32'hFFFFFFFF, 0, rd, er, lat, h, ra);
            checks++;
            if (rd !== 32'd0 || er !== 1'b1) begin
                errors++; $display("FAIL err_case%0d: got %h/%b expected 00000000/1", i, rd, er);
            end
        end
        do_req(1'b0, `MEM_LW, 32'h10, 32'd0, 0, rd, er, lat, h, ra);
        checks++;
        if (rd !== 32'hAB011234 || er !== 1'b0) begin
            errors++; $display("FAIL mem_untouched: got %h/%b expected ab011234/0", rd, er);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, mrd, addr, wdata; logic er, mer, wr; logic [3:0] op;
        int lat; bit h, ra;
        sel = 0;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) < 8) begin
                op = 4'($urandom_range(0, 7));
                wr = (op >= `MEM_SB);
            end else begin
                op = 4'($urandom_range(0, 15));
                wr = 1'($urandom_range(0, 1));
            end
            case ($urandom_range(0, 9))
                0:       addr = $urandom();
                1:       addr = 32'hFF8 + 32'($urandom_range(0, 15));
                default: addr = 32'($urandom_range(0, 63));
            endcase
            wdata = $urandom();
            model_step(wr, op, addr, wdata, mrd, mer);
            do_req(wr, op, addr, wdata, 0, rd, er, lat, h, ra);
            checks++;
            if (rd !== mrd || er !== mer || lat != 1 || !h) begin
                errors++;
                $display("FAIL random%0d op %0d wr %b addr %h: got %h/%b lat %0d expected %h/%b lat 1",
                         i, op, wr, addr, rd, er, lat, mrd, mer);
            end
        end
    endtask

    task automatic test_latency_stall();
        logic [31:0] rd; logic er; int lat; bit h, ra;
        sel = 1;
        do_req(1'b1, `MEM_SW, 32'h40, 32'hCAFEF00D, 0, rd, er, lat, h, ra);
        checks++;
        if (rd !== 32'd0 || er !== 1'b0 || lat != 4) begin
            errors++; $display("FAIL lat4_store: got %h/%b lat %0d expected 00000000/0 lat 4", rd, er, lat);
        end
        do_req(1'b0, `MEM_LW, 32'h40, 32'd0, 3, rd, er, lat, h, ra);
        checks++;
        if (rd !== 32'hCAFEF00D || er !== 1'b0 || lat != 4) begin
            errors++; $display("FAIL lat4_load: got %h/%b lat %0d expected cafef00d/0 lat 4", rd, er, lat);
        end
        checks++;
        if (!h) begin errors++; $display("FAIL stall_hold: got unstable response or ready high expected held"); end
        checks++;
        if (!ra) begin errors++; $display("FAIL ready_after_handshake: got 0 expected 1"); end
        do_req(1'b0, `MEM_LH, 32'h42, 32'd0, 1, rd, er, lat, h, ra);
        checks++;
        if (rd !== 32'hFFFFCAFE || er !== 1'b0 || lat != 4 || !h) begin
            errors++; $display("FAIL lat4_lh: got %h/%b lat %0d expected ffffcafe/0 lat 4", rd, er, lat);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat; bit h, ra;
        int n; bit bad;
        sel = 1;
        r_valid = 1'b1; r_wr = 1'b1; r_op = `MEM_SW; r_addr = 32'h20; r_wdata = 32'hFFFFFFFF;
        @(posedge clk);
        @(negedge clk);
        r_valid = 1'b0;
        @(negedge clk);
        rst1 = 1'b1;
        #1;
        checks++;
        if ({o_valid, o_ready, o_busy} !== 3'b001) begin
            errors++; $display("FAIL mid_reset_flags: got %b expected 001", {o_valid, o_ready, o_busy});
        end
        bad = 0;
        repeat (3) begin @(negedge clk); if (o_valid) bad = 1; end
        rst1 = 1'b0;
        n = 0;
        while (o_busy && n < 3000) begin
            if (o_valid || o_ready) bad = 1;
            n++;
            @(negedge clk);
        end
        checks++;
        if (bad || n != 1024) begin
            errors++; $display("FAIL reclear: got cycles %0d bad %b expected 1024/0", n, bad);
        end
        do_req(1'b0, `MEM_LW, 32'h20, 32'd0, 0, rd, er, lat, h, ra);
        checks++;
        if (rd !== 32'd0 || er !== 1'b0) begin
            errors++; $display("FAIL aborted_store: got %h/%b expected 00000000/0", rd, er);
        end
        do_req(1'b0, `MEM_LW, 32'h40, 32'd0, 0, rd, er, lat, h, ra);
        checks++;
        if (rd !== 32'd0 || er !== 1'b0) begin
            errors++; $display("FAIL recleared_word: got %h/%b expected 00000000/0", rd, er);
        end
    endtask

    initial begin
        test_reset();
        test_byte_half();
        test_partial_store();
        test_errors();
        test_random();
        test_latency_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
